// File: rtl/threshold_fifo_if.sv
// ============================================================================
// Module      : threshold_fifo_if
// Description : Bus bundle for threshold_fifo. Carries the producer/consumer
//               handshake (clear, we/din, re/dout/dout_valid) together with
//               the occupancy flags, the entry count and the sticky error
//               flags.
//               master : the side driving requests (clear, we, din, re).
//               slave  : the FIFO itself, driving data, flags and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface threshold_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic             clear;
    logic             we;
    logic [WIDTH-1:0] din;
    logic             re;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [DEPTH:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, we, din, re,
        input  dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  clear, we, din, re,
        output dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/threshold_fifo.sv
// ============================================================================
// Module      : threshold_fifo
// Description : Synchronous FIFO with 2**DEPTH entries, programmable
//               almost-full / almost-empty thresholds, sticky overflow and
//               underflow flags and a synchronous flush (clear).
//               Output mode is chosen at compile time with the macro
//               THRESHOLD_FIFO_FWFT_EN:
//                 defined   : first-word-fall-through; dout is read
//                             combinationally from memory, dout_valid = ~empty
//                 undefined : registered read; dout loads on an accepted read
//                             and dout_valid pulses for one cycle
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - threshold_fifo_if.slave (requests in; data, flags,
//                          count and error flags out)
// Parameters  : WIDTH    - data width
//               DEPTH    - log2 of entry count
//               AF_LEVEL - almost_full when count >= AF_LEVEL
//               AE_LEVEL - almost_empty when count <= AE_LEVEL
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module threshold_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 2**DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    threshold_fifo_if.slave       bus
);

    localparam int             ENTRIES   = 2**DEPTH;
    localparam logic [DEPTH:0] AF_THRESH = (DEPTH+1)'(AF_LEVEL);
    localparam logic [DEPTH:0] AE_THRESH = (DEPTH+1)'(AE_LEVEL);
    localparam logic           AF_RESET  = (AF_LEVEL == 0);

    generate
        if ((DEPTH < 1) || (AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) ||
            (AF_LEVEL > ENTRIES)) begin : g_param_check
            $error("threshold_fifo: illegal DEPTH/AE_LEVEL/AF_LEVEL combination");
        end
    endgenerate

    // Storage is deliberately not reset.
    logic [WIDTH-1:0] mem [ENTRIES];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without comparing against the FIFO size.
    logic [DEPTH:0] wr_ptr;
    logic [DEPTH:0] rd_ptr;
    logic [DEPTH:0] wr_ptr_nxt;
    logic [DEPTH:0] rd_ptr_nxt;
    logic [DEPTH:0] count_nxt;

    logic ptr_empty;
    logic ptr_full;
    logic full_nxt;
    logic rd_accept;
    logic wr_accept;

    logic [DEPTH:0] count_q;
    logic           empty_q;
    logic           full_q;
    logic           almost_empty_q;
    logic           almost_full_q;
    logic           overflow_q;
    logic           underflow_q;

    // ------------------------------------------------------------------------
    // Acceptance and next-state pointers
    // ------------------------------------------------------------------------
    always_comb begin
        ptr_empty = (wr_ptr == rd_ptr);
        ptr_full  = (wr_ptr[DEPTH-1:0] == rd_ptr[DEPTH-1:0]) &&
                    (wr_ptr[DEPTH] != rd_ptr[DEPTH]);

        // A write into a full FIFO is still taken when the same edge frees a
        // slot; the slot being written is exactly the one being read, and the
        // read sees the old contents because memory updates non-blocking.
        rd_accept = bus.re && !bus.clear && !ptr_empty;
        wr_accept = bus.we && !bus.clear && (!ptr_full || rd_accept);

        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        if (bus.clear) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
        end else begin
            if (rd_accept) rd_ptr_nxt = rd_ptr + 1'b1;
            if (wr_accept) wr_ptr_nxt = wr_ptr + 1'b1;
        end

        count_nxt = wr_ptr_nxt - rd_ptr_nxt;
        full_nxt  = (wr_ptr_nxt[DEPTH-1:0] == rd_ptr_nxt[DEPTH-1:0]) &&
                    (wr_ptr_nxt[DEPTH] != rd_ptr_nxt[DEPTH]);
    end

    // ------------------------------------------------------------------------
    // Pointers, registered flags and sticky error flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= AF_RESET;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            count_q        <= count_nxt;
            empty_q        <= (wr_ptr_nxt == rd_ptr_nxt);
            full_q         <= full_nxt;
            almost_empty_q <= (count_nxt <= AE_THRESH);
            almost_full_q  <= (count_nxt >= AF_THRESH);
            if (bus.clear) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                if (bus.we && !wr_accept) overflow_q  <= 1'b1;
                if (bus.re && !rd_accept) underflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr[DEPTH-1:0]] <= bus.din;
    end

    assign bus.count        = count_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
`ifdef THRESHOLD_FIFO_FWFT_EN
    // Head of queue is always on dout; a read simply advances rd_ptr.
    assign bus.dout       = mem[rd_ptr[DEPTH-1:0]];
    assign bus.dout_valid = ~empty_q;
`else
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    // dout holds the last word read (also across clear); dout_valid marks
    // only the cycle right after an accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (bus.clear) begin
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_accept;
            if (rd_accept) dout_q <= mem[rd_ptr[DEPTH-1:0]];
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
`endif

endmodule

`default_nettype wire

// File: doc/threshold_fifo.md
# threshold_fifo

Parametrised synchronous FIFO with a power-of-two depth. It adds programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a compile-time choice between registered-read and first-word-fall-through output. It sits between streaming producer/consumer stages in generated designs, where the simple single-flag FIFO lacks back-pressure headroom and error visibility.

## Interface
- WIDTH, 32, data width in bits.
- DEPTH, 8, log2 of entry count; FIFO holds 2**DEPTH entries.
- AF_LEVEL, 2**DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; overrides re/we.
- we  input  1  write request.
- din  input  WIDTH  write data.
- re  input  1  read request.
- dout  output  WIDTH  read data.
- dout_valid  output  1  dout holds a freshly read word (see Configuration).
- empty  output  1  no entries.
- full  output  1  2**DEPTH entries.
- almost_empty  output  1  count <= AE_LEVEL.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  DEPTH+1  current entry count, 0..2**DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

## Operation
- Pointers: wr_ptr and rd_ptr are DEPTH+1 bits wide. The low DEPTH bits address memory, and the MSB is a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ. Natural modulo 2**(DEPTH+1) wrap; no explicit compare against FIFO size.
- Read accepted when re=1 and the FIFO is non-empty (pre-edge state); rd_ptr increments. re=1 while empty is rejected: rd_ptr unchanged, underflow set to 1.
- Write accepted when we=1 and either (a) the FIFO is not full, or (b) it is full and a read is accepted in the same cycle. mem[wr_ptr] <= din; wr_ptr increments. Otherwise the write is rejected: no memory write, overflow set to 1.
- Simultaneous re/we:
  - Empty: write accepted, read rejected (underflow=1), count becomes 1.
  - Full: both accepted, count unchanged, full stays 1.
- count = wr_ptr - rd_ptr (DEPTH+1-bit subtraction). empty, full, almost_* and count are registered from the next-state pointers.
- clear=1: pointers go to 0; flags, count, overflow and underflow take their reset values; dout_valid=0. Memory contents are untouched and dout is held. re/we in the same cycle are ignored and set no error flags.
- Reset (async assert, any time, including mid-burst):
  - empty=1, full=0, count=0, almost_empty=1.
  - almost_full = (AF_LEVEL==0).
  - overflow=0, underflow=0, dout=0, dout_valid=0.
  - Memory is not reset.
- Parameter constraints: 0 <= AE_LEVEL < AF_LEVEL <= 2**DEPTH. DEPTH >= 1.

## Timing
- Write-to-flag latency: 1 cycle. A write accepted at edge N is reflected in count, empty and almost_* after edge N.
- Write-to-read: a word written at edge N is readable (re accepted) at edge N+1 at the earliest.
- Registered mode: a read accepted at edge N loads dout at edge N, and dout_valid=1 for that one cycle. dout holds its value until the next accepted read. Back-to-back reads give one word per cycle.
- FWFT mode: dout = mem[rd_ptr low bits] combinationally, and dout_valid = ~empty. The read at edge N pops the displayed word, and the next word appears after edge N.
- Error flags set on the edge of the rejected request. They clear only on reset_n or clear.

## Configuration
- THRESHOLD_FIFO_FWFT_EN defined: first-word-fall-through output. dout is combinational from memory, and dout_valid mirrors ~empty. The dout reset value is don't-care.
- Undefined (default): registered read output with 1-cycle latency and single-cycle dout_valid pulses, as in Timing. All other behaviour is identical in both modes.

## Test plan
Common configuration: WIDTH=16, DEPTH=3, AF_LEVEL=6, AE_LEVEL=1.
- **Fill and drain:** write 0x0001..0x0008 on consecutive cycles.
  - almost_full after the 6th write; full=1 and count=8 after the 8th.
  - Then read 8 times: data 0x0001..0x0008 in order; empty=1 and almost_empty=1 at the end; no error flags.
- **Overflow:** with the FIFO full, we=1 and din=0xDEAD.
  - overflow=1, count stays 8.
  - Subsequent reads never return 0xDEAD.
- **Underflow and simultaneous access while empty:** re=1 and we=1, din=0x00AA.
  - underflow=1, count=1.
  - The next read returns 0x00AA.
- **Simultaneous access while full:** re=1 and we=1, din=0x0099.
  - count stays 8, full=1, no overflow.
  - The 8th subsequent read returns 0x0099.
- **Pointer wrap:** perform 20 write/read pairs with values 0..19 at count 3. Read data matches in order, and count stays 3.
- **Flush and reset:**
  - clear mid-stream with count=5 and re=we=1: count=0, empty=1, overflow/underflow=0, no read/write effect.
  - Assert reset_n low between clock edges: outputs reach their reset values immediately, before the next edge.
